// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 S-box store: FSM state encoding,
// init-mode selectors and default geometry.
package rc4_pkg;

    // Default geometry: 256 entries of 8 bits, the classic RC4 state array.
    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_AW = 8;

    // Init sweep fill patterns.
    localparam int INIT_IDENTITY = 1;  // mem[k] = k
    localparam int INIT_ZERO     = 0;  // mem[k] = 0

    // Controller states.
    //   ST_INIT    : sweep writes every entry with its init value
    //   ST_READY   : idle, accepts init / swap / write requests
    //   ST_SWAP_RD : capture both swap operands
    //   ST_SWAP_WR : write operands back crosswise
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_READY   = 2'd1,
        ST_SWAP_RD = 2'd2,
        ST_SWAP_WR = 2'd3
    } state_t;

endpackage

// File: rtl/rc4_ram_core.sv
// DEPTH x DW storage array for the RC4 S-box.
// One registered read port for the user, two synchronous write ports
// (port B wins on an address collision) and a dual-address
// asynchronous read port used only by the swap engine.
module rc4_ram_core #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    // user read port, latency 1
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    // write port A
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    // write port B
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    // swap-engine read port
    input  logic [AW-1:0] xaddr_i,
    input  logic [AW-1:0] xaddr_j,
    output logic [DW-1:0] xdata_i,
    output logic [DW-1:0] xdata_j
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage update: port A first, port B second so B wins on the same address.
    // NOTE: the array has no reset; the controller's init sweep fills it, which
    // keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= data_a;
        end
        if (we_b) begin
            mem[addr_b] <= data_b;
        end
    end

    // Registered user read; returns the value held before any same-cycle write.
    // NOTE: non-blocking assignment here and in the write block is what gives
    // read-first behaviour; a blocking write would leak the new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

    // Swap operands are looked up directly; the controller registers them.
    assign xdata_i = mem[xaddr_i];
    assign xdata_j = mem[xaddr_j];

endmodule

// File: rtl/rc4_sbox_ram.sv
// RC4 S-box store: self-initialising state array with a registered read
// port, a direct write port and an atomic swap engine, so the KSA/PRGA
// controllers issue S[i]<->S[j] as a single request.
module rc4_sbox_ram
    import rc4_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int AW        = DEFAULT_AW,
    parameter int INIT_MODE = INIT_IDENTITY
) (
    input  logic          clk,
    input  logic          rst_n,
    // control
    input  logic          init_req,
    output logic          ready,
    // read port
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    // direct write port
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          wr_ack,
    // swap engine
    input  logic          swap_valid,
    input  logic [AW-1:0] swap_i,
    input  logic [AW-1:0] swap_j,
    output logic          swap_ready,
    output logic          swap_done,
    output logic [DW-1:0] swap_si,
    output logic [DW-1:0] swap_sj
);

    // Last address of the sweep; reaching it ends INIT.
    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] i_q;
    logic [AW-1:0] j_q;
    logic [DW-1:0] si_q;
    logic [DW-1:0] sj_q;
    logic [DW-1:0] xdata_i;
    logic [DW-1:0] xdata_j;
    logic [DW-1:0] init_val;

    logic          rd_accept;
    logic          swap_accept;
    logic          init_accept;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;

    // Identity fill is the counter zero-extended to the entry width.
    assign init_val = (INIT_MODE == INIT_IDENTITY) ? DW'(cnt_q) : '0;

    assign ready       = (state_q == ST_READY);
    assign swap_ready  = ready;
    assign init_accept = ready && init_req;
    assign swap_accept = ready && !init_req && swap_valid;
    assign rd_accept   = rd_en && (state_q != ST_INIT);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; priority in READY is init_req > swap_valid > wr_en.
    // NOTE: state_d is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_INIT;
                end else if (swap_valid) begin
                    state_d = ST_SWAP_RD;
                end
            end
            ST_SWAP_RD: state_d = ST_SWAP_WR;
            ST_SWAP_WR: state_d = ST_READY;
        endcase
    end

    // Output logic: write-port steering and the direct-write acknowledge.
    always_comb begin
        wr_ack = 1'b0;
        we_a   = 1'b0;
        addr_a = waddr;
        data_a = wdata;
        we_b   = 1'b0;
        addr_b = j_q;
        data_b = si_q;
        unique case (state_q)
            ST_INIT: begin
                we_a   = 1'b1;
                addr_a = cnt_q;
                data_a = init_val;
            end
            ST_READY: begin
                if (wr_en && !init_req && !swap_valid) begin
                    wr_ack = 1'b1;
                    we_a   = 1'b1;
                end
            end
            ST_SWAP_RD: begin
                // operands are captured in the datapath block
            end
            ST_SWAP_WR: begin
                // port A carries mem[i] <= old S[j], port B mem[j] <= old S[i];
                // for i==j both carry the same value, so the entry is unchanged
                we_a   = 1'b1;
                addr_a = i_q;
                data_a = sj_q;
                we_b   = 1'b1;
            end
        endcase
    end

    // Init counter: advances through the sweep, rewinds on an accepted init_req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (init_accept) begin
            cnt_q <= '0;
        end
    end

    // Swap datapath: latch indices on accept, capture operands in SWAP_RD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q  <= '0;
            j_q  <= '0;
            si_q <= '0;
            sj_q <= '0;
        end else begin
            if (swap_accept) begin
                i_q <= swap_i;
                j_q <= swap_j;
            end
            if (state_q == ST_SWAP_RD) begin
                si_q <= xdata_i;
                sj_q <= xdata_j;
            end
        end
    end

    // Completion reporting: swap_done pulses in the first READY cycle after
    // SWAP_WR; the old values stay on swap_si/swap_sj until the next commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_done <= 1'b0;
            swap_si   <= '0;
            swap_sj   <= '0;
        end else begin
            swap_done <= (state_q == ST_SWAP_WR);
            if (state_q == ST_SWAP_WR) begin
                swap_si <= si_q;
                swap_sj <= sj_q;
            end
        end
    end

    // Read-valid pulse, one cycle after an accepted read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_accept;
        end
    end

    rc4_ram_core #(
        .DW (DW),
        .AW (AW)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_accept),
        .raddr   (raddr),
        .rdata   (rdata),
        .we_a    (we_a),
        .addr_a  (addr_a),
        .data_a  (data_a),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .data_b  (data_b),
        .xaddr_i (i_q),
        .xaddr_j (j_q),
        .xdata_i (xdata_i),
        .xdata_j (xdata_j)
    );

endmodule

// File: tb/tb_rc4_sbox_ram.sv
// Testbench for rc4_sbox_ram (DW=8, AW=8, identity init).
// Stimulus pushes expected read data and swap results into queues; a
// monitor on the falling edge pops and compares whenever rvalid or
// swap_done is presented.
module tb_rc4_sbox_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0;
    logic       ready;
    logic       rd_en = 1'b0;
    logic [7:0] raddr = '0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       wr_en = 1'b0;
    logic [7:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       wr_ack;
    logic       swap_valid = 1'b0;
    logic [7:0] swap_i = '0;
    logic [7:0] swap_j = '0;
    logic       swap_ready;
    logic       swap_done;
    logic [7:0] swap_si;
    logic [7:0] swap_sj;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  model [256];
    logic [7:0]  rd_q [$];
    logic [15:0] sw_q [$];

    rc4_sbox_ram #(
        .DW        (8),
        .AW        (8),
        .INIT_MODE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req   (init_req),
        .ready      (ready),
        .rd_en      (rd_en),
        .raddr      (raddr),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .wr_en      (wr_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .wr_ack     (wr_ack),
        .swap_valid (swap_valid),
        .swap_i     (swap_i),
        .swap_j     (swap_j),
        .swap_ready (swap_ready),
        .swap_done  (swap_done),
        .swap_si    (swap_si),
        .swap_sj    (swap_sj)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, starting from n0 edges already elapsed.
    task automatic wait_ready(input int n0, input int exp_edges, input string name);
        int n;
        n = n0;
        while (!ready && n < 400) begin
            tick();
            n++;
        end
        check(name, n, exp_edges);
    endtask

    task automatic model_identity();
        for (int k = 0; k < 256; k++) model[k] = 8'(k);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
        rd_en = 1'b1;
        raddr = addr;
        rd_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic dump();
        for (int k = 0; k < 256; k++) do_read(8'(k), model[k]);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input logic exp_ack);
        wr_en = 1'b1;
        waddr = addr;
        wdata = data;
        #1;
        check("wr_ack", wr_ack, exp_ack);
        if (exp_ack) model[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Issues a swap, expects the given old values and a 3-cycle commit;
    // drops every request line once the swap is accepted.
    task automatic do_swap(input logic [7:0] i, input logic [7:0] j,
                           input logic [7:0] exp_si, input logic [7:0] exp_sj);
        int n;
        logic [7:0] tmp;
        swap_valid = 1'b1;
        swap_i = i;
        swap_j = j;
        #1;
        check("wr_ack during swap request", wr_ack, 1'b0);
        sw_q.push_back({exp_si, exp_sj});
        tmp = model[i];
        model[i] = model[j];
        model[j] = tmp;
        tick();
        swap_valid = 1'b0;
        wr_en = 1'b0;
        n = 1;
        while (!swap_done && n < 20) begin
            tick();
            n++;
        end
        check("swap latency", n, 3);
        check("ready after swap", ready, 1'b1);
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected rvalid", 1, 0);
            else check("rdata", rdata, rd_q.pop_front());
        end
        if (swap_done === 1'b1) begin
            if (sw_q.size() == 0) begin
                check("unexpected swap_done", 1, 0);
            end else begin
                logic [15:0] e;
                e = sw_q.pop_front();
                check("swap_si", swap_si, e[15:8]);
                check("swap_sj", swap_sj, e[7:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- 1: reset state, init sweep timing, ignored inputs in INIT ----
        repeat (3) tick();
        check("reset ready", ready, 1'b0);
        check("reset rvalid", rvalid, 1'b0);
        check("reset swap_done", swap_done, 1'b0);
        check("reset rdata", rdata, 8'h00);
        check("reset swap_si", swap_si, 8'h00);
        check("reset swap_sj", swap_sj, 8'h00);
        check("reset swap_ready", swap_ready, 1'b0);
        rst_n = 1'b1;
        wr_en = 1'b1; waddr = 8'h02; wdata = 8'h55;
        rd_en = 1'b1; raddr = 8'h00;
        swap_valid = 1'b1; init_req = 1'b1;
        repeat (10) tick();
        check("wr_ack in INIT", wr_ack, 1'b0);
        check("ready in INIT", ready, 1'b0);
        wr_en = 1'b0; rd_en = 1'b0; swap_valid = 1'b0; init_req = 1'b0;
        wait_ready(10, 256, "init cycles after reset");
        model_identity();
        do_read(8'h37, 8'h37);

        // ---- 2: basic swap ----
        do_swap(8'd3, 8'd200, 8'd3, 8'd200);
        do_read(8'd3, 8'd200);
        do_read(8'd200, 8'd3);

        // ---- 3: self swap, full dump ----
        do_swap(8'd5, 8'd5, 8'd5, 8'd5);
        dump();

        // ---- 4: swap beats a same-cycle write ----
        wr_en = 1'b1; waddr = 8'h10; wdata = 8'h99;
        do_swap(8'h40, 8'h41, 8'h40, 8'h41);
        do_read(8'h10, 8'h10);
        do_read(8'h40, 8'h41);
        do_read(8'h41, 8'h40);
        do_write(8'h60, 8'h5A, 1'b1);
        do_read(8'h60, 8'h5A);

        // back-to-back swaps sharing an index
        do_swap(8'd7, 8'd8, 8'd7, 8'd8);
        do_swap(8'd7, 8'd9, 8'd8, 8'd9);

        // ---- 5: read-first on a same-cycle write ----
        rd_en = 1'b1; raddr = 8'h20;
        wr_en = 1'b1; waddr = 8'h20; wdata = 8'hAA;
        rd_q.push_back(8'h20);
        #1;
        check("wr_ack read-first", wr_ack, 1'b1);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        model[8'h20] = 8'hAA;
        do_read(8'h20, 8'hAA);

        // ---- 6a: reset during SWAP_RD (also mid-read) ----
        swap_valid = 1'b1; swap_i = 8'd1; swap_j = 8'd2;
        tick();
        swap_valid = 1'b0;
        rd_en = 1'b1; raddr = 8'h00;
        rst_n = 1'b0;
        tick();
        rd_en = 1'b0;
        check("ready after mid-swap reset", ready, 1'b0);
        check("swap_done after mid-swap reset", swap_done, 1'b0);
        check("rvalid after mid-read reset", rvalid, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ready(0, 256, "init cycles after mid-swap reset");
        model_identity();
        dump();

        // ---- 6b: init_req re-init after writes (init_req beats swap_valid) ----
        do_write(8'h00, 8'hFF, 1'b1);
        do_write(8'h80, 8'h01, 1'b1);
        init_req = 1'b1; swap_valid = 1'b1; swap_i = 8'd0; swap_j = 8'd1;
        wr_en = 1'b1; waddr = 8'h30; wdata = 8'h77;
        #1;
        check("wr_ack with init_req", wr_ack, 1'b0);
        tick();
        init_req = 1'b0; swap_valid = 1'b0; wr_en = 1'b0;
        check("ready after init_req", ready, 1'b0);
        wait_ready(0, 256, "re-init cycles");
        model_identity();
        dump();

        repeat (4) tick();
        check("read queue drained", rd_q.size(), 0);
        check("swap queue drained", sw_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
